mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Round-robin arbiter sharing one single-port memory between NUM_REQ requesters.
//  Sits between the requester agents and the memory's valid/ready slave interface.
//  Grants one requester at a time, forwards its addr/wdata/wr_rd and returns rdata/ready.
//  A watchdog releases the bus if the memory never answers.
// PARAMETERS
//  NUM_REQ     4            number of requesters (>=2)
//  ADDR_WIDTH  `ADDR_WIDTH  memory address width
//  WIDTH       `WIDTH       data width
//  TIMEOUT     16           max cycles mem_valid may wait for mem_ready (>=2)
// PORTS
//  clk        in   1                   single clock, all logic on posedge
//  rst        in   1                   synchronous, active-low reset
//  req_valid  in   NUM_REQ             per-requester request
//  req_wr_rd  in   NUM_REQ             1=write 0=read, per requester
//  req_addr   in   NUM_REQ*ADDR_WIDTH  flattened, requester i at [i*ADDR_WIDTH+:ADDR_WIDTH]
//  req_wdata  in   NUM_REQ*WIDTH       flattened write data
//  req_ready  out  NUM_REQ             one-hot completion pulse to granted requester
//  req_rdata  out  WIDTH               read data; valid only with req_ready on a read
//  req_err    out  NUM_REQ             one-cycle timeout pulse to granted requester
//  mem_valid  out  1                   request to memory
//  mem_wr_rd  out  1                   to memory
//  mem_addr   out  ADDR_WIDTH          to memory
//  mem_wdata  out  WIDTH               to memory
//  mem_rdata  in   WIDTH               from memory, sampled with mem_ready
//  mem_ready  in   1                   memory completion
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE; mem_valid=0; mem_wr_rd/addr/wdata=0; req_err=0;
//   rr pointer=0 (requester 0 highest priority); watchdog=0. Aborts any transfer in flight.
//  FSM IDLE: if |req_valid, rr_arbiter picks the first set bit starting at ptr, wrapping
//   at NUM_REQ-1 -> 0. Registers the grant index and that requester's wr_rd/addr/wdata.
//   Sets mem_valid=1 next cycle. -> BUSY. Zero requests: stay IDLE, mem_valid=0.
//  FSM BUSY: mem_valid and payload held stable. Watchdog increments each cycle.
//   mem_ready==1: req_ready[grant]=mem_ready (combinational, same cycle).
//    req_rdata=mem_rdata (combinational). ptr<=grant+1 (mod NUM_REQ). mem_valid<=0. -> IDLE.
//   Watchdog reaches TIMEOUT-1 without mem_ready: req_err[grant] pulses 1 cycle,
//    mem_valid<=0, ptr<=grant+1, -> IDLE.
//   mem_ready on the timeout cycle: completion wins, no err.
//  Latency: req_valid seen in IDLE -> mem_valid 1 cycle later.
//   Ready memory (ready one cycle after valid) -> req_ready 2 cycles after grant sample.
//   Back-to-back throughput: one transfer per 3 cycles (one IDLE bubble).
//  req_ready/req_err are 0 outside BUSY. req_rdata=0 when no req_ready.
//  mem_ready while IDLE is ignored.
//  Requester dropping req_valid while granted: transfer still completes; its req_ready
//   still pulses. Payload changes after grant are ignored (latched copy is used).
//  Fairness: a requester waits at most NUM_REQ-1 grants. Granted requester gets lowest
//   priority next round.
//  Invariant: mem_addr/mem_wr_rd/mem_wdata are never X while mem_valid==1.
// STRUCTURE
//  mem_arb_pkg: state_t enum {IDLE,BUSY}, default NUM_REQ/TIMEOUT constants,
//   function for one-hot<->index.
//  Sub-module rr_arbiter (combinational): req vector + ptr -> grant index + any_grant.
//   Kept separate for reuse.
//  mem_arbiter: FSM, payload/grant registers, watchdog counter ($clog2(TIMEOUT) bits),
//   output decode.
// TESTING
//  1. Reset: rst=0 2 cycles with req_valid=4'b1111 -> mem_valid=0, req_ready=0, req_err=0.
//  2. Single write: req0 wr addr=0x10 wdata=0xA5, mem ready 1 cycle after valid
//     -> mem_addr=0x10, mem_wdata=0xA5; req_ready=4'b0001 for exactly 1 cycle.
//  3. Fairness: req_valid=4'b1111 held -> grant order 0,1,2,3,0.
//     Then req_valid=4'b1010 -> grants 1,3,1.
//  4. Read: memory returns 0x3C with ready on a req2 read -> req_rdata=0x3C when req_ready=4'b0100.
//  5. Timeout: mem_ready tied 0, req1 request -> req_err=4'b0010 after TIMEOUT cycles of
//     mem_valid; FSM returns to IDLE and serves req2 next.
//  6. Mid-op reset: rst=0 while BUSY -> next cycle mem_valid=0, ptr=0; a late mem_ready
//     produces no req_ready.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types, default sizes and one-hot helpers for the memory arbiter.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef WIDTH
`define WIDTH 8
`endif

package mem_arb_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_TIMEOUT = 16;

  // Legacy state encodings, kept as constants so older code can still compare against them
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY
  } state_t;

  // Index -> one-hot (supports up to 32 requesters)
  function automatic logic [31:0] idx2onehot(input int unsigned idx);
    return 32'd1 << idx;
  endfunction

  // One-hot -> index (highest set bit wins if more than one is set)
  function automatic int unsigned onehot2idx(input logic [31:0] oh);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of the arbiter. The arbiter itself uses the
// slave view (it serves the requesters); the environment uses the master view.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef WIDTH
`define WIDTH 8
`endif

interface mem_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
  parameter int unsigned WIDTH      = `WIDTH
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_wr_rd;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]      req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [WIDTH-1:0]              req_rdata;
  logic [NUM_REQ-1:0]            req_err;
  logic                          mem_valid;
  logic                          mem_wr_rd;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [WIDTH-1:0]              mem_wdata;
  logic [WIDTH-1:0]              mem_rdata;
  logic                          mem_ready;

  modport slave (
    input  req_valid, req_wr_rd, req_addr, req_wdata, mem_rdata, mem_ready,
    output req_ready, req_rdata, req_err, mem_valid, mem_wr_rd, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_wr_rd, req_addr, req_wdata, mem_rdata, mem_ready,
    input  req_ready, req_rdata, req_err, mem_valid, mem_wr_rd, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDXW    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    ptr,
  output logic [IDXW-1:0]    grant_idx,
  output logic               any_grant
);

  // Scan requesters starting at ptr; the first hit wins
  always_comb begin
    int unsigned k;
    logic [IDXW-1:0] kk;
    grant_idx = '0;
    any_grant = 1'b0;
    k         = 0;
    kk        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = 32'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      kk = IDXW'(k);
      if (!any_grant && req[kk]) begin
        any_grant = 1'b1;
        grant_idx = kk;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ requesters,
// with a watchdog that releases the bus if the memory never answers.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
  parameter int unsigned WIDTH      = `WIDTH,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned IDXW = $clog2(NUM_REQ);
  localparam int unsigned WDW  = $clog2(TIMEOUT);

  state_t                  state;
  logic [IDXW-1:0]         ptr;
  logic [IDXW-1:0]         grant;
  logic [IDXW-1:0]         arb_idx;
  logic                    arb_any;
  logic [WDW-1:0]          wd;
  logic                    mv;
  logic                    mwr;
  logic [ADDR_WIDTH-1:0]   maddr;
  logic [WIDTH-1:0]        mwdata;
  logic                    busy;
  logic                    done;
  logic                    expire;
  logic [IDXW-1:0]         next_ptr;
  logic [31:0]             grant_oh;
  logic [NUM_REQ-1:0]      ready_vec;
  logic [NUM_REQ-1:0]      err_vec;
  logic [WIDTH-1:0]        rdata;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_rr (
    .req       (bus.req_valid),
    .ptr       (ptr),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  // Completion / timeout decode and response routing to the granted requester
  always_comb begin
    busy      = (state == BUSY);
    done      = busy && bus.mem_ready;
    expire    = busy && !bus.mem_ready && (wd == WDW'(TIMEOUT - 1));
    next_ptr  = (grant == IDXW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    grant_oh  = idx2onehot(32'(grant));
    ready_vec = done   ? grant_oh[NUM_REQ-1:0] : '0;
    err_vec   = expire ? grant_oh[NUM_REQ-1:0] : '0;
    rdata     = done   ? bus.mem_rdata : '0;
  end

  // FSM, latched payload, round-robin pointer and watchdog
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      mv     <= 1'b0;
      mwr    <= 1'b0;
      maddr  <= '0;
      mwdata <= '0;
      ptr    <= '0;
      grant  <= '0;
      wd     <= '0;
    end else begin
      case (state)
        IDLE: begin
          wd <= '0;
          if (arb_any) begin
            grant  <= arb_idx;
            mwr    <= bus.req_wr_rd[arb_idx];
            maddr  <= bus.req_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
            mwdata <= bus.req_wdata[arb_idx*WIDTH +: WIDTH];
            mv     <= 1'b1;
            state  <= BUSY;
          end
        end
        BUSY: begin
          // Completion and timeout share the same exit; ready on the last cycle wins
          if (bus.mem_ready || (wd == WDW'(TIMEOUT - 1))) begin
            mv    <= 1'b0;
            ptr   <= next_ptr;
            wd    <= '0;
            state <= IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_valid = mv;
  assign bus.mem_wr_rd = mwr;
  assign bus.mem_addr  = maddr;
  assign bus.mem_wdata = mwdata;
  assign bus.req_ready = ready_vec;
  assign bus.req_err   = err_vec;
  assign bus.req_rdata = rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transfer scoreboard.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;

  logic clk;
  logic rst;

  mem_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .WIDTH(DW)) bus ();

  mem_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW),
    .WIDTH      (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int unsigned   idx;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        e0;
  int          errors = 0;
  int          checks = 0;
  int unsigned cycles;
  int unsigned n;
  bit          got;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int unsigned idx, input logic wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bus.req_wr_rd[idx]          = wr;
    bus.req_addr[idx*AW +: AW]  = addr;
    bus.req_wdata[idx*DW +: DW] = wdata;
  endtask

  task automatic push(input int unsigned idx, input logic wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
    exp_t e;
    e.idx = idx; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Wait for a grant, check it against the scoreboard head, then complete it
  // with the memory answering lat cycles after mem_valid was seen.
  task automatic serve(input int unsigned lat, input bit drop);
    exp_t        e;
    int unsigned k;
    bit          seen;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (bus.mem_valid === 1'b1) seen = 1'b1;
    end
    check("valid_seen", 32'(seen), 32'd1);
    if (!seen) return;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_underflow: got grant with no expectation queued");
      return;
    end
    e = sb.pop_front();
    check("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
    check("mem_wr_rd", 32'(bus.mem_wr_rd), 32'(e.wr));
    check("mem_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
    check("early_ready", 32'(bus.req_ready), 32'd0);
    if (drop) begin
      bus.req_valid[e.idx]          = 1'b0;
      bus.req_wr_rd[e.idx]          = ~e.wr;
      bus.req_addr[e.idx*AW +: AW]  = ~e.addr;
      bus.req_wdata[e.idx*DW +: DW] = ~e.wdata;
    end
    repeat (lat) begin
      @(negedge clk);
      check("valid_held", 32'(bus.mem_valid), 32'd1);
      check("addr_held", 32'(bus.mem_addr), 32'(e.addr));
      check("wdata_held", 32'(bus.mem_wdata), 32'(e.wdata));
      check("wait_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = e.rdata;
    #1;
    check("req_ready", 32'(bus.req_ready), 32'd1 << e.idx);
    check("req_rdata", 32'(bus.req_rdata), 32'(e.rdata));
    check("no_err", 32'(bus.req_err), 32'd0);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    #1;
    check("ready_pulse", 32'(bus.req_ready), 32'd0);
    check("bubble", 32'(bus.mem_valid), 32'd0);
    check("rdata_idle", 32'(bus.req_rdata), 32'd0);
  endtask

  initial begin
    rst           = 1'b0;
    bus.req_valid = '0;
    bus.req_wr_rd = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;

    // Reset with every requester asking
    bus.req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_err", 32'(bus.req_err), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    bus.req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    check("idle_valid", 32'(bus.mem_valid), 32'd0);

    // Single write from requester 0
    set_req(0, 1'b1, 8'h10, 8'hA5);
    push(0, 1'b1, 8'h10, 8'hA5, 8'h00);
    bus.req_valid = 4'b0001;
    serve(1, 1'b1);

    // Fairness from a fresh pointer
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int unsigned i = 0; i < NR; i++) begin
      set_req(i, i[0], 8'(32'h20 + i), 8'(32'h40 + i));
    end
    push(0, 1'b0, 8'h20, 8'h40, 8'h80);
    push(1, 1'b1, 8'h21, 8'h41, 8'h81);
    push(2, 1'b0, 8'h22, 8'h42, 8'h82);
    push(3, 1'b1, 8'h23, 8'h43, 8'h83);
    push(0, 1'b0, 8'h20, 8'h40, 8'h84);
    bus.req_valid = 4'b1111;
    repeat (5) serve(1, 1'b0);
    bus.req_valid = 4'b1010;
    push(1, 1'b1, 8'h21, 8'h41, 8'h91);
    push(3, 1'b1, 8'h23, 8'h43, 8'h93);
    push(1, 1'b1, 8'h21, 8'h41, 8'h95);
    repeat (3) serve(1, 1'b0);
    bus.req_valid = '0;

    // Read from requester 2
    set_req(2, 1'b0, 8'h33, 8'h99);
    push(2, 1'b0, 8'h33, 8'h99, 8'h3C);
    bus.req_valid = 4'b0100;
    serve(1, 1'b1);

    // Timeout on requester 1, then requester 2 is served next
    set_req(1, 1'b0, 8'h51, 8'h11);
    set_req(2, 1'b1, 8'h52, 8'h77);
    push(1, 1'b0, 8'h51, 8'h11, 8'h00);
    push(2, 1'b1, 8'h52, 8'h77, 8'h5A);
    bus.req_valid = 4'b0110;
    e0     = sb.pop_front();
    cycles = 0;
    got    = 1'b0;
    n      = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.mem_valid === 1'b1) begin
        cycles++;
        if (cycles == 1) check("to_addr", 32'(bus.mem_addr), 32'(e0.addr));
        if (bus.req_err !== '0) got = 1'b1;
      end
    end
    check("to_seen", 32'(got), 32'd1);
    check("to_cycles", cycles, TO);
    check("to_err", 32'(bus.req_err), 32'b0010);
    check("to_noready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("to_err_pulse", 32'(bus.req_err), 32'd0);
    check("to_release", 32'(bus.mem_valid), 32'd0);
    serve(1, 1'b1);
    bus.req_valid = '0;

    // Reset in the middle of a transfer
    set_req(3, 1'b1, 8'h63, 8'h36);
    bus.req_valid = 4'b1000;
    got = 1'b0;
    n   = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.mem_valid === 1'b1) got = 1'b1;
    end
    check("mid_seen", 32'(got), 32'd1);
    check("mid_addr", 32'(bus.mem_addr), 32'h63);
    bus.req_valid = '0;
    rst = 1'b0;
    @(negedge clk);
    check("mid_valid", 32'(bus.mem_valid), 32'd0);
    check("mid_addr_clr", 32'(bus.mem_addr), 32'd0);
    rst           = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 8'hEE;
    #1;
    check("late_ready", 32'(bus.req_ready), 32'd0);
    check("late_rdata", 32'(bus.req_rdata), 32'd0);
    check("late_err", 32'(bus.req_err), 32'd0);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    check("late_idle", 32'(bus.mem_valid), 32'd0);
    // Pointer is back at 0, so requester 0 beats requester 3
    set_req(0, 1'b0, 8'h70, 8'h07);
    push(0, 1'b0, 8'h70, 8'h07, 8'hC3);
    bus.req_valid = 4'b1001;
    serve(1, 1'b1);
    bus.req_valid = '0;
    @(negedge clk);
    check("final_idle", 32'(bus.mem_valid), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
